// File: rtl/plot_fb_receiver_if.sv
// Plot-request, scan-read and framebuffer RAM signals grouped for plot_fb_receiver.
// Latency: none (wiring only).
// Backpressure: ready is advisory; the producer may ignore it and plots are then dropped.
interface plot_fb_receiver_if;
    logic        plot;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        ready;
    logic        overflow;
    logic        clear_overflow;
    logic [7:0]  drop_count;
    logic        scan_req;
    logic [7:0]  scan_x;
    logic [6:0]  scan_y;
    logic        scan_busy;
    logic        scan_valid;
    logic [2:0]  scan_colour;
    logic [14:0] mem_addr;
    logic [2:0]  mem_wdata;
    logic        mem_we;
    logic [2:0]  mem_rdata;

    modport master (
        output plot, x, y, colour, clear_overflow, scan_req, scan_x, scan_y, mem_rdata,
        input  ready, overflow, drop_count, scan_busy, scan_valid, scan_colour,
               mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  plot, x, y, colour, clear_overflow, scan_req, scan_x, scan_y, mem_rdata,
        output ready, overflow, drop_count, scan_busy, scan_valid, scan_colour,
               mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/plot_fb_receiver.sv
// Buffers pixel plots in a FIFO and writes them to a 160x120x3 framebuffer; serves scan-out reads first.
// Latency: plot to mem_we 2 cycles when idle; scan_req to scan_valid 3 cycles.
// Backpressure: none upstream; plots arriving on a full FIFO or out of range are dropped and counted.
module plot_fb_receiver #(
    parameter int FIFO_DEPTH = 8
) (
    input logic             clk,
    input logic             resetn,
    plot_fb_receiver_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef struct packed {
        logic [14:0] addr;
        logic [2:0]  colour;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

    // y*160 + x built from shifts so no multiplier is needed
    function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
        return ({8'd0, py} << 7) + ({8'd0, py} << 5) + {7'd0, px};
    endfunction

    entry_t          fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic            fifo_full, in_range, push, pop, drop_range, drop_full;

    state_t          state, state_nx;
    logic [14:0]     scan_addr;
    logic            scan_pending, clr_pending, capture;
    logic            we_q, we_nx;
    logic [14:0]     addr_q, addr_nx;
    logic [2:0]      wdata_q, wdata_nx;
    logic            scan_valid_q;
    logic [2:0]      scan_colour_q;
    logic            overflow_q;
    logic [7:0]      drop_q;

    assign fifo_full  = (count == CNT_FULL);
    assign in_range   = (bus.x <= 8'd159) && (bus.y <= 7'd119);
    // fullness is judged on the count before any same-cycle pop
    assign push       = bus.plot && in_range && !fifo_full;
    assign drop_range = bus.plot && !in_range;
    assign drop_full  = bus.plot && in_range && fifo_full;

    // FIFO payload storage; contents need no reset since count gates reads
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{addr: pix_addr(bus.x, bus.y), colour: bus.colour};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // sticky overflow flag and saturating drop counter; clear beats a coincident drop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else if (bus.clear_overflow) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else begin
            if (drop_full) overflow_q <= 1'b1;
            if ((drop_range || drop_full) && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    // latch one scan request while no read is outstanding
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            scan_pending <= 1'b0;
            scan_addr    <= '0;
        end else if (bus.scan_req && !bus.scan_busy) begin
            scan_pending <= 1'b1;
            scan_addr    <= pix_addr(bus.scan_x, bus.scan_y);
        end else if (clr_pending) begin
            scan_pending <= 1'b0;
        end
    end

    // state register plus registered RAM port and read-result outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            scan_valid_q  <= 1'b0;
            scan_colour_q <= '0;
        end else begin
            state        <= state_nx;
            we_q         <= we_nx;
            addr_q       <= addr_nx;
            wdata_q      <= wdata_nx;
            scan_valid_q <= capture;
            if (capture) scan_colour_q <= bus.mem_rdata;
        end
    end

    // next state: pending read beats queued writes; IDLE, WR and RD_WAIT share dispatch rules
    always_comb begin
        state_nx    = state;
        pop         = 1'b0;
        we_nx       = 1'b0;
        addr_nx     = addr_q;
        wdata_nx    = wdata_q;
        clr_pending = 1'b0;
        capture     = 1'b0;
        case (state)
            RD: begin
                state_nx = RD_WAIT;
            end
            default: begin
                capture = (state == RD_WAIT);
                if (scan_pending) begin
                    state_nx    = RD;
                    clr_pending = 1'b1;
                    addr_nx     = scan_addr;
                end else if (count != '0) begin
                    state_nx = WR;
                    pop      = 1'b1;
                    we_nx    = 1'b1;
                    addr_nx  = fifo_mem[rd_ptr].addr;
                    wdata_nx = fifo_mem[rd_ptr].colour;
                end else begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    assign bus.ready       = !fifo_full;
    assign bus.overflow    = overflow_q;
    assign bus.drop_count  = drop_q;
    assign bus.scan_busy   = scan_pending || (state == RD) || (state == RD_WAIT);
    assign bus.scan_valid  = scan_valid_q;
    assign bus.scan_colour = scan_colour_q;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
endmodule

// File: doc/plot_fb_receiver.md
# plot_fb_receiver

Receiving end of the pixel-plot interface (`plot`/`x`/`y`/`colour`) driven by the game controller. It buffers plot requests in a small FIFO and writes them into a 160x120x3 single-port synchronous framebuffer RAM. It also services single-pixel read requests from the display scan-out logic, which take priority over queued writes. It sits between the game control path and the framebuffer, in place of the direct write port of the VGA adapter.

## Interface
- `FIFO_DEPTH`, default 8: plot FIFO entries; must be a power of two, at least 2.
- `clk` in 1: system clock (50 MHz).
- `resetn` in 1: reset, asynchronous, active-low.
- `plot` in 1: write request; sampled every rising edge.
- `x` in 8: pixel column, valid range 0..159.
- `y` in 7: pixel row, valid range 0..119.
- `colour` in 3: pixel colour {R,G,B}.
- `ready` out 1: FIFO not full. Advisory only; the producer need not honour it.
- `overflow` out 1: sticky. Set when a plot is dropped because the FIFO is full.
- `clear_overflow` in 1: synchronous clear of `overflow` and `drop_count`.
- `drop_count` out 8: saturating count of dropped plots (full FIFO or out-of-range coordinate).
- `scan_req` in 1: read request for pixel (`scan_x`, `scan_y`).
- `scan_x` in 8, `scan_y` in 7: read coordinate.
- `scan_busy` out 1: a read is pending or in progress; `scan_req` is ignored while this is high.
- `scan_valid` out 1: one-cycle pulse marking `scan_colour` valid.
- `scan_colour` out 3: read result; holds its value until the next read.
- `mem_addr` out 15, `mem_wdata` out 3, `mem_we` out 1: RAM port; all registered.
- `mem_rdata` in 3: RAM read data, valid one cycle after the address is presented.

## Operation
- Address computation: addr = y*160 + x = (y<<7)+(y<<5)+x, evaluated at 15 bits. Range is 0..19199; no wrap.
- Acceptance: a plot with x>159 or y>119 is dropped and `drop_count` increments; `overflow` is not set. A plot while the FIFO is full (count == FIFO_DEPTH, judged before any same-cycle pop) is dropped, `drop_count` increments and `overflow` is set. Any other plot is pushed as {addr, colour}.
- `drop_count` saturates at 255. If `clear_overflow` and a drop coincide, the clear wins.
- Scan capture: when `scan_req`=1 and `scan_busy`=0, the scan address is registered and `scan_pending` is set. `scan_busy` = scan_pending or state in {RD, RD_WAIT}.
- FSM states and transitions:
  - IDLE: if scan_pending, go to RD. Otherwise, if FIFO not empty, pop and go to WR. Otherwise stay in IDLE.
  - WR: mem_we=1, mem_addr/mem_wdata from the popped entry. If scan_pending, go to RD. Otherwise, if FIFO not empty, pop and stay in WR (back-to-back writes). Otherwise go to IDLE.
  - RD: mem_we=0, mem_addr = scan address, scan_pending cleared. Go to RD_WAIT.
  - RD_WAIT: capture mem_rdata into scan_colour and pulse scan_valid on the next cycle. Transitions follow the IDLE rules.
- The FSM exits at the same edge it captures read data, so the scan_valid pulse overlaps the next state.
- Writes are committed in FIFO order. A read issued after a write to the same pixel has been committed to RAM returns the new colour. Reads do not snoop the FIFO.

## Timing
- Reset values: state IDLE, FIFO empty, ready=1, overflow=0, drop_count=0, scan_busy=0, scan_valid=0, scan_colour=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Asserting resetn mid-operation discards FIFO contents, any pending read and any in-flight write. mem_we drops immediately (asynchronously).
- Write latency, block idle: plot sampled at edge t gives mem_we=1 with the matching address in the cycle after edge t+1.
- Sustained write throughput is one per clock. A stream of one plot per cycle never fills the FIFO if there are no reads.
- Read latency: scan_req at edge t puts RD in the cycle after edge t+1, RD_WAIT after edge t+2, and scan_valid=1 in the cycle after edge t+3.
- Each read costs 2 cycles of write bandwidth.
- `ready` and `overflow` update at the edge that changes the FIFO count or drops a plot.

## Test plan
- Single plot x=0, y=1, colour=5 after reset -> exactly one mem_we pulse, 2 cycles later, with mem_addr=160 and mem_wdata=5.
- Corner plot x=159, y=119 gives mem_addr=19199. Plot x=160, y=0 and x=0, y=120 -> no mem_we, drop_count=2, overflow=0.
- 20 consecutive plots at one per cycle with no scans -> 20 consecutive mem_we cycles in order, ready stays 1.
- Plot every cycle for 64 cycles with scan_req every 4th cycle -> ready deasserts, overflow=1, and (mem_we count + drop_count) = 64. clear_overflow then gives overflow=0, drop_count=0.
- Write (10,10,colour 3), wait for commit, then scan_req (10,10) -> scan_valid 3 cycles later with scan_colour=3. A second scan_req while scan_busy=1 is ignored.
- Reset asserted while 5 entries are queued -> mem_we=0 immediately, no further writes after release, ready=1.
